// File: rtl/clk_div_r1.sv
// Multi-channel clock-enable divider: per-channel pulse or square enables derived
// from one system clock, with shadowed config applied glitch-free at wrap/sync/disable.
module clk_div_r1 #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned DIV_INIT  = 2,
    parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic                 cfg_mode,
    output logic                 cfg_ack,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    tick
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    cnt_t act_div_q [NUM_CH];
    cnt_t act_div_d [NUM_CH];
    cnt_t sh_div_q  [NUM_CH];
    cnt_t sh_div_d  [NUM_CH];
    cnt_t cnt_q     [NUM_CH];
    cnt_t cnt_d     [NUM_CH];
    cnt_t nxt_div   [NUM_CH];

    logic [NUM_CH-1:0] act_mode_q, act_mode_d;
    logic [NUM_CH-1:0] sh_mode_q, sh_mode_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] wr_hit, wrap, copy, nxt_mode, nxt_pend;
    logic              ack_q, err_q;

    always_comb begin
        act_div_d  = act_div_q;
        sh_div_d   = sh_div_q;
        cnt_d      = cnt_q;
        nxt_div    = sh_div_q;
        act_mode_d = act_mode_q;
        sh_mode_d  = sh_mode_q;
        pend_d     = pend_q;
        tick_d     = tick_q;
        wr_hit     = '0;
        wrap       = '0;
        copy       = '0;
        nxt_mode   = sh_mode_q;
        nxt_pend   = pend_q;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            // A same-cycle write bypasses the shadow so it is what gets applied
            wr_hit[c]   = cfg_wr && ({1'b0, cfg_ch} == (CH_W+1)'(c));
            nxt_div[c]  = wr_hit[c] ? cfg_div  : sh_div_q[c];
            nxt_mode[c] = wr_hit[c] ? cfg_mode : sh_mode_q[c];
            nxt_pend[c] = pend_q[c] | wr_hit[c];
            wrap[c]     = (act_div_q[c] == '0) ? (cnt_q[c] == '0)
                                               : (cnt_q[c] == act_div_q[c] - cnt_t'(1));
            sh_div_d[c]  = nxt_div[c];
            sh_mode_d[c] = nxt_mode[c];
            pend_d[c]    = nxt_pend[c];

            if (sync || !ch_en[c]) begin
                cnt_d[c]  = '0;
                tick_d[c] = 1'b0;
            end else if (en) begin
                if (wrap[c]) begin
                    cnt_d[c]  = '0;
                    tick_d[c] = act_mode_q[c] ? ~tick_q[c] : 1'b1;
                end else begin
                    cnt_d[c]  = cnt_q[c] + cnt_t'(1);
                    tick_d[c] = act_mode_q[c] ? tick_q[c] : 1'b0;
                end
            end

            copy[c] = nxt_pend[c] && (sync || !ch_en[c] || (en && wrap[c]));
            if (copy[c]) begin
                act_div_d[c]  = nxt_div[c];
                act_mode_d[c] = nxt_mode[c];
                pend_d[c]     = 1'b0;
                tick_d[c]     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                act_div_q[c] <= cnt_t'(DIV_INIT);
                sh_div_q[c]  <= cnt_t'(DIV_INIT);
                cnt_q[c]     <= '0;
            end
            act_mode_q <= '0;
            sh_mode_q  <= '0;
            pend_q     <= '0;
            tick_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            act_div_q  <= act_div_d;
            sh_div_q   <= sh_div_d;
            cnt_q      <= cnt_d;
            act_mode_q <= act_mode_d;
            sh_mode_q  <= sh_mode_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            ack_q      <= cfg_wr;
            err_q      <= cfg_wr && ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_r1.sv
// Self-checking bench for clk_div_r1: directed scenarios plus random traffic,
// compared every cycle against a behavioural per-channel model.
module tb_clk_div_r1;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int CHW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en, sync, cfg_wr, cfg_mode, cfg_ack, cfg_err;
    logic [NCH-1:0] ch_en, tick;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;

    int checks   = 0;
    int failures = 0;

    int m_div[NCH], m_sh_div[NCH], m_cnt[NCH];
    bit m_mode[NCH], m_sh_mode[NCH], m_pend[NCH], m_tick[NCH];
    bit m_ack, m_err;

    always #5 clk = ~clk;

    clk_div_r1 #(.NUM_CH(NCH), .CNT_WIDTH(CW), .DIV_INIT(2), .CH_W(CHW)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .ch_en(ch_en),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .tick(tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i] = 2; m_sh_div[i] = 2; m_cnt[i] = 0;
            m_mode[i] = 0; m_sh_mode[i] = 0; m_pend[i] = 0; m_tick[i] = 0;
        end
        m_ack = 0; m_err = 0;
    endfunction

    // Elapsed-count view: a period ends once E counting cycles have passed.
    function automatic void model_edge();
        for (int i = 0; i < NCH; i++) begin
            int  e;
            bit  ended;
            e = (m_div[i] == 0) ? 1 : m_div[i];
            ended = 0;
            if (cfg_wr && int'(cfg_ch) == i) begin
                m_sh_div[i] = int'(cfg_div); m_sh_mode[i] = cfg_mode; m_pend[i] = 1;
            end
            if (sync || !ch_en[i]) begin
                m_cnt[i] = 0; m_tick[i] = 0;
            end else if (en) begin
                m_cnt[i]++;
                if (m_cnt[i] == e) begin
                    m_cnt[i] = 0; ended = 1;
                    m_tick[i] = m_mode[i] ? !m_tick[i] : 1'b1;
                end else if (!m_mode[i]) begin
                    m_tick[i] = 0;
                end
            end
            if (m_pend[i] && (sync || !ch_en[i] || ended)) begin
                m_div[i] = m_sh_div[i]; m_mode[i] = m_sh_mode[i];
                m_pend[i] = 0; m_tick[i] = 0;
            end
        end
        m_ack = cfg_wr;
        m_err = cfg_wr && (int'(cfg_ch) >= NCH);
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) chk($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tick[i]));
        chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        cfg_wr = 0;
        sync   = 0;
    endtask

    task automatic wr(input int ch, input int d, input bit mode);
        cfg_wr = 1; cfg_ch = CHW'(ch); cfg_div = CW'(d); cfg_mode = mode;
    endtask

    task automatic do_reset();
        en = 0; sync = 0; ch_en = '0; cfg_wr = 0; cfg_ch = '0; cfg_div = '0; cfg_mode = 0;
        @(negedge clk);
        rst = 1;
        #1;
        model_reset();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_ack", 32'(cfg_ack), 0);
        chk("rst_err", 32'(cfg_err), 0);
        #2 rst = 0;
    endtask

    initial begin
        logic [3:0]  t1_exp [4];
        logic [11:0] pat12;
        logic [8:0]  pat9;
        int          first, second, npulse;

        t1_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};

        // Reset and default pulse
        do_reset();
        en = 1; ch_en = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_pulse", 32'(tick), 32'(t1_exp[i]));
        end

        // Square mode on ch1, D=3
        wr(1, 3, 1);
        step();
        chk("t2_ack", 32'(cfg_ack), 1);
        ch_en = 4'b0011;
        pat12 = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            pat12 = {pat12[10:0], tick[1]};
        end
        chk("t2_square", 32'(pat12), 32'(12'b001110001110));

        // Glitch-free update: write mid-period, then on the wrap cycle
        for (int k = 0; k < 2; k++) begin
            do_reset();
            wr(0, 5, 0);
            step();
            en = 1; ch_en = 4'b0001;
            pat9 = '0;
            for (int i = 1; i <= 9; i++) begin
                if (i == ((k == 0) ? 2 : 5)) wr(0, 2, 0);
                step();
                pat9 = {pat9[7:0], tick[0]};
            end
            chk(k == 0 ? "t3_mid" : "t3_wrap", 32'(pat9), 32'(9'b000000101));
        end

        // D=0 and D=1 give a continuous pulse
        do_reset();
        wr(0, 0, 0); step();
        wr(1, 1, 0); step();
        en = 1; ch_en = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_cont", 32'(tick), 32'(4'b0011));
        end

        // Out-of-range channel write
        wr(NCH, 7, 1);
        step();
        chk("t5_ack", 32'(cfg_ack), 1);
        chk("t5_err", 32'(cfg_err), 1);
        step();
        chk("t5_ack_clr", 32'(cfg_ack), 0);
        for (int i = 0; i < 4; i++) step();

        // Pause stretches the period by the paused cycles
        do_reset();
        wr(0, 5, 0); step();
        ch_en = 4'b0001;
        first = -1; second = -1;
        for (int i = 1; i <= 20; i++) begin
            en = (i >= 7 && i <= 10) ? 1'b0 : 1'b1;
            step();
            if (tick[0] && first < 0) first = i;
            else if (tick[0] && second < 0) second = i;
        end
        chk("t6_first", 32'(first), 5);
        chk("t6_period", 32'(second - first), 9);

        // Sync aligns D=3 and D=6
        do_reset();
        wr(0, 3, 0); step();
        wr(1, 6, 0); step();
        en = 1; ch_en = 4'b0011;
        for (int i = 0; i < 4; i++) step();
        sync = 1;
        step();
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 3) chk("t7_s3", 32'(tick[1:0]), 32'(2'b01));
            if (i == 6) chk("t7_s6", 32'(tick[1:0]), 32'(2'b11));
        end

        // Async reset mid-count, then DIV_INIT behaviour
        step(); step();
        do_reset();
        en = 1; ch_en = 4'b0011;
        step();
        step();
        chk("t8_init", 32'(tick), 32'(4'b0011));

        // Maximum divide value
        do_reset();
        wr(0, 65535, 0); step();
        en = 1; ch_en = 4'b0001;
        first = -1; npulse = 0;
        for (int i = 1; i <= 65536; i++) begin
            step();
            if (tick[0]) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        chk("t9_first", 32'(first), 65535);
        chk("t9_count", 32'(npulse), 1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom % 8) != 0;
            sync     = ($urandom % 64) == 0;
            ch_en    = 4'($urandom) | 4'($urandom) | 4'($urandom);
            cfg_wr   = ($urandom % 6) == 0;
            cfg_ch   = CHW'($urandom_range(0, 5));
            cfg_div  = CW'($urandom_range(0, 6));
            cfg_mode = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
